// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the accumulator ALU sequencer: op codes, FSM states,
// response flag bundle and default datapath width.
package alu_sequencer_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;
  localparam int unsigned OP_W          = 3;

  localparam logic [OP_W-1:0] OP_ADD  = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB  = 3'b001;
  localparam logic [OP_W-1:0] OP_MUL  = 3'b010;
  localparam logic [OP_W-1:0] OP_DIV  = 3'b011;
  localparam logic [OP_W-1:0] OP_LOAD = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  typedef struct packed {
    logic zero;
    logic neg;
    logic err;
  } rsp_flags_t;

endpackage

// File: rtl/alu_sequencer_if.sv
// Command/response handshake bundle between a command producer (master)
// and the ALU sequencer (slave).
interface alu_sequencer_if
  import alu_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
);

  logic                cmd_valid;
  logic                cmd_ready;
  logic [OP_W-1:0]     cmd_op;
  logic [WIDTH-1:0]    cmd_operand;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [WIDTH-1:0]    rsp_data;
  logic                rsp_zero;
  logic                rsp_neg;
  logic                rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_operand, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_zero, rsp_neg, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_operand, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_zero, rsp_neg, rsp_err
  );

endinterface

// File: rtl/alu_sequencer_alu.sv
// Combinational two's-complement ALU; error conditions are decoded by the
// sequencer, so divide-by-zero and illegal selects simply yield benign values here.
module alu
  import alu_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic [OP_W-1:0]  alu_sel,
  input  logic [WIDTH-1:0] bus_a,
  input  logic [WIDTH-1:0] bus_b,
  output logic [WIDTH-1:0] alu_out,
  output logic             zero,
  output logic             negative
);

  logic signed [WIDTH-1:0] sa;
  logic signed [WIDTH-1:0] sb;

  assign sa = $signed(bus_a);
  assign sb = $signed(bus_b);

  // Divide by -1 is done as negation so most-negative wraps back to itself.
  always_comb begin
    alu_out = bus_a;
    case (alu_sel)
      OP_ADD:  alu_out = bus_a + bus_b;
      OP_SUB:  alu_out = bus_a - bus_b;
      OP_MUL:  alu_out = WIDTH'(bus_a * bus_b);
      OP_DIV: begin
        if (bus_b == '0) begin
          alu_out = '0;
        end else if (bus_b == '1) begin
          alu_out = '0 - bus_a;
        end else begin
          alu_out = $unsigned(sa / sb);
        end
      end
      OP_LOAD: alu_out = bus_b;
      default: alu_out = bus_a;
    endcase
  end

  assign zero     = (alu_out == '0);
  assign negative = alu_out[WIDTH-1];

endmodule

// File: rtl/alu_sequencer.sv
// Accumulator sequencer: accepts one command in IDLE, computes it in EXEC and
// holds the registered result in RESP until the consumer takes it.
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic            clk,
  input  logic            rstn,
  alu_sequencer_if.slave  bus
);

  state_e           state_q;
  state_e           state_d;
  logic [WIDTH-1:0] acc_q;
  logic [OP_W-1:0]  op_q;
  logic [WIDTH-1:0] operand_q;
  logic             cmd_ready_q;
  logic             rsp_valid_q;
  logic [WIDTH-1:0] rsp_data_q;
  rsp_flags_t       flags_q;

  logic             cmd_fire;
  logic             exec_en;
  logic             cmd_err;
  logic [WIDTH-1:0] result;
  rsp_flags_t       result_flags;

  logic [WIDTH-1:0] alu_out;
  logic             alu_zero;
  logic             alu_neg;

  alu #(.WIDTH(WIDTH)) u_alu (
    .alu_sel  (op_q),
    .bus_a    (acc_q),
    .bus_b    (operand_q),
    .alu_out  (alu_out),
    .zero     (alu_zero),
    .negative (alu_neg)
  );

  assign cmd_fire = bus.cmd_valid && cmd_ready_q;

  // Next-state, error decode and result selection.
  always_comb begin
    state_d      = state_q;
    exec_en      = 1'b0;
    cmd_err      = 1'b0;
    result       = alu_out;
    result_flags = '{zero: alu_zero, neg: alu_neg, err: 1'b0};

    case (state_q)
      ST_IDLE: if (cmd_fire) state_d = ST_EXEC;
      ST_EXEC: begin
        state_d = ST_RESP;
        exec_en = 1'b1;
      end
      ST_RESP: if (bus.rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if ((op_q > OP_LOAD) || ((op_q == OP_DIV) && (operand_q == '0))) begin
      cmd_err      = 1'b1;
      result       = acc_q;
      result_flags = '{zero: (acc_q == '0), neg: acc_q[WIDTH-1], err: 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Handshake outputs track the state being entered so they are registered.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      cmd_ready_q <= (state_d == ST_IDLE);
      rsp_valid_q <= (state_d == ST_RESP);
    end
  end

  // Command capture, accumulator update and response registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_q      <= '0;
      op_q       <= '0;
      operand_q  <= '0;
      rsp_data_q <= '0;
      flags_q    <= '0;
    end else begin
      if (cmd_fire) begin
        op_q      <= bus.cmd_op;
        operand_q <= bus.cmd_operand;
      end
      if (exec_en) begin
        rsp_data_q <= result;
        flags_q    <= result_flags;
        if (!cmd_err) begin
          acc_q <= alu_out;
        end
      end
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_zero  = flags_q.zero;
  assign bus.rsp_neg   = flags_q.neg;
  assign bus.rsp_err   = flags_q.err;

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter: WIDTH, default 8, datapath and accumulator width in bits.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rstn  input  1  asynchronous, active-low reset.
REQ-004 cmd_valid  input  1  command offered this cycle.
REQ-005 cmd_ready  output  1  sequencer accepts a command this cycle.
REQ-006 cmd_op  input  3  operation code (see REQ-011).
REQ-007 cmd_operand  input  WIDTH  signed operand B.
REQ-008 rsp_valid  output  1  response held for the consumer.
REQ-009 rsp_ready  input  1  consumer takes the response this cycle.
REQ-010 rsp_data  output  WIDTH  accumulator value after the command.
REQ-010a rsp_zero, rsp_neg, rsp_err  output  1 each  zero flag, sign flag (rsp_data MSB), error flag.

Function
REQ-011 Op codes: 000 ADD acc+B; 001 SUB acc-B; 010 MUL, low WIDTH bits of acc*B; 011 DIV, signed acc/B truncated toward zero; 100 LOAD acc<=B; 101-111 illegal.
REQ-012 All arithmetic SHALL be two's complement, modulo 2^WIDTH, with no saturation; DIV of most-negative by -1 SHALL return most-negative with rsp_err=0.
REQ-013 FSM states IDLE, EXEC, RESP; the only transitions SHALL be IDLE->EXEC on cmd_valid&&cmd_ready, EXEC->RESP unconditionally, RESP->IDLE on rsp_ready, with every other condition holding state.
REQ-014 cmd_ready SHALL be 1 only in IDLE; in IDLE, cmd_op and cmd_operand SHALL be captured into internal registers on the handshake edge.
REQ-015 In EXEC, the sub-module SHALL compute from the accumulator and the captured operand, and the result and flags SHALL be registered at the end of EXEC.
REQ-016 rsp_valid SHALL be 1 exactly in RESP; latency from the cmd handshake edge to rsp_valid=1 SHALL be 2 cycles, and peak throughput SHALL be one command per 3 cycles.
REQ-017 rsp_data and all flags SHALL stay stable while rsp_valid=1 and rsp_ready=0.
REQ-018 DIV with B=0 or an illegal op SHALL set rsp_err=1, leave the accumulator unchanged, and report rsp_data = unchanged accumulator, with zero/neg flags computed from it.
REQ-019 rsp_zero SHALL equal (rsp_data==0) and rsp_neg SHALL equal rsp_data[WIDTH-1], both for every response including error responses.
REQ-020 cmd_valid while not in IDLE SHALL be ignored and SHALL have no effect on state or outputs.
REQ-021 The accumulator SHALL persist across commands and SHALL change only at the end of EXEC for a non-error command.

Reset
REQ-022 rstn=0 SHALL at once force the FSM to IDLE and clear the accumulator and captured registers to 0.
REQ-023 rstn=0 SHALL at once force rsp_valid=0, rsp_data=0, rsp_zero=0, rsp_neg=0, rsp_err=0.
REQ-024 While rstn=0, cmd_ready SHALL be 0; after reset release it SHALL go to 1 on the first cycle.
REQ-025 Reset asserted in EXEC or RESP SHALL abort the command with no response and no accumulator update.

Structure
REQ-026 A shared package SHALL hold the op-code constants (OP_ADD..OP_LOAD), the FSM state enum type, and the default WIDTH.
REQ-027 The combinational arithmetic SHALL be one sub-module, alu (inputs alu_sel, bus_a, bus_b; outputs alu_out, zero, negative), instantiated once with bus_a=accumulator and bus_b=captured operand.
REQ-028 The divide-by-zero and illegal-op decode SHALL live in alu_sequencer and not in alu.

Verification
REQ-029 Reset: assert rstn=0 mid-run -> rsp_valid=0, rsp_data=0, and cmd_ready=1 on the first cycle after release.
REQ-030 LOAD 5 then ADD 10 -> rsp_data=0x0F, zero=0, neg=0, err=0, with rsp_valid exactly 2 cycles after each accept.
REQ-031 LOAD 30, SUB -10 (0xF6) -> 0x28; then SUB 50 -> 0xF6 with neg=1; then LOAD 0 -> zero=1.
REQ-032 LOAD 51, DIV 17 -> 0x03; then DIV 0 -> err=1 and rsp_data=0x03; then MUL 5 -> 0x0F.
REQ-033 Backpressure: hold rsp_ready=0 for 5 cycles with cmd_valid=1 -> response stable, cmd_ready=0, no extra command taken.
REQ-034 Op 3'b110 -> err=1 with accumulator unchanged; reset pulse during EXEC -> no response and accumulator=0.
